hbuf_pkt_loader: RTL

// - Upstream stage of the mDOM hit buffer controller: drains waveform packets from the wvb reader

---
 rtl/hbuf_pkt_loader.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/hbuf_pkt_loader.sv
// hbuf_pkt_loader: moves one wvb packet at a time from the reader FIFOs into the hit-buffer
// readout DPRAM and hands it to the controller. Optional statistics: `define HBUF_LDR_CNT_EN.
module hbuf_pkt_loader #(
    parameter logic [15:0] P_MAX_LEN = 16'd2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        pkt_rdy,
    input  logic [15:0] pkt_len,
    output logic        pkt_ack,
    input  logic        data_empty,
    output logic        data_rd_en,
    input  logic [31:0] data_in,
    output logic        rdout_dpram_wren,
    output logic [9:0]  rdout_dpram_wr_addr,
    output logic [31:0] rdout_dpram_data,
    output logic [15:0] dpram_len_out,
    output logic        rdout_dpram_run,
    input  logic        dpram_busy,
    output logic [31:0] n_pkts,
    output logic [15:0] n_drops
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READ      = 3'd1,
        S_RUN       = 3'd2,
        S_ARM       = 3'd3,
        S_BUSY_WAIT = 3'd4,
        S_DROP      = 3'd5
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        clr_s;
    logic        accept_s;
    logic        rd_s;
    logic        last_wr_s;
    logic [16:0] len_p1_s;
    logic [15:0] n32_s;
    logic [15:0] len_r;
    logic [15:0] n32_r;
    logic [15:0] rd_cnt_r;
    logic [15:0] wr_cnt_r;
    logic        wren_r;
    logic [9:0]  wr_addr_r;
    logic        run_r;
    logic [15:0] len_out_r;

    assign clr_s     = rst | ~en;
    assign len_p1_s  = {1'b0, pkt_len} + 17'd1;
    assign n32_s     = 16'(len_p1_s >> 1);
    assign last_wr_s = wren_r & (wr_cnt_r == (n32_r - 16'd1));

    // Next-state and FIFO strobe decode
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        rd_s        = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (pkt_rdy && !dpram_busy) begin
                    accept_s = 1'b1;
                    if (pkt_len == 16'd0) begin
                        state_nxt_s = S_IDLE;
                    end else if (pkt_len > P_MAX_LEN) begin
                        state_nxt_s = S_DROP;
                    end else begin
                        state_nxt_s = S_READ;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_READ: begin
                rd_s = !data_empty && (rd_cnt_r < n32_r);
                if (last_wr_s) begin
                    state_nxt_s = S_RUN;
                end else begin
                    state_nxt_s = S_READ;
                end
            end
            S_RUN:  state_nxt_s = S_ARM;
            S_ARM:  state_nxt_s = S_BUSY_WAIT;
            S_BUSY_WAIT: begin
                if (!dpram_busy) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_BUSY_WAIT;
                end
            end
            S_DROP: begin
                // Oversize packet: drain it so the FIFOs stay aligned, never write it
                rd_s = !data_empty && (rd_cnt_r < n32_r);
                if (rd_s && (rd_cnt_r == (n32_r - 16'd1))) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DROP;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register; rst or en low parks the loader in idle
    always_ff @(posedge clk) begin
        if (clr_s) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Packet bookkeeping and registered DPRAM-side outputs
    always_ff @(posedge clk) begin
        if (clr_s) begin
            len_r     <= 16'd0;
            n32_r     <= 16'd0;
            rd_cnt_r  <= 16'd0;
            wr_cnt_r  <= 16'd0;
            wren_r    <= 1'b0;
            wr_addr_r <= 10'd0;
            run_r     <= 1'b0;
            len_out_r <= 16'd0;
        end else begin
            wren_r <= (state_r == S_READ) && rd_s;
            run_r  <= (state_nxt_s == S_RUN);
            if (accept_s) begin
                len_r     <= pkt_len;
                n32_r     <= n32_s;
                rd_cnt_r  <= 16'd0;
                wr_cnt_r  <= 16'd0;
                wr_addr_r <= 10'd0;
            end else begin
                if (rd_s) begin
                    rd_cnt_r <= rd_cnt_r + 16'd1;
                end
                if (wren_r) begin
                    wr_cnt_r <= wr_cnt_r + 16'd1;
                    // Hold on the final word so a full 1024-word packet never wraps
                    if (!last_wr_s) begin
                        wr_addr_r <= wr_addr_r + 10'd1;
                    end
                end
            end
            if (state_nxt_s == S_RUN) begin
                len_out_r <= len_r;
            end
        end
    end

    assign pkt_ack             = accept_s & ~clr_s;
    assign data_rd_en          = rd_s & ~clr_s;
    assign rdout_dpram_wren    = wren_r;
    assign rdout_dpram_wr_addr = wr_addr_r;
    assign rdout_dpram_data    = wren_r ? data_in : 32'd0;
    assign dpram_len_out       = len_out_r;
    assign rdout_dpram_run     = run_r;

`ifdef HBUF_LDR_CNT_EN
    logic [31:0] n_pkts_r;
    logic [15:0] n_drops_r;
    logic        drop_s;

    assign drop_s = pkt_ack & (pkt_len > P_MAX_LEN);

    // Saturating statistics, cleared by rst only so they survive en toggles
    always_ff @(posedge clk) begin
        if (rst) begin
            n_pkts_r  <= 32'd0;
            n_drops_r <= 16'd0;
        end else begin
            if (run_r && (n_pkts_r != 32'hFFFF_FFFF)) begin
                n_pkts_r <= n_pkts_r + 32'd1;
            end
            if (drop_s && (n_drops_r != 16'hFFFF)) begin
                n_drops_r <= n_drops_r + 16'd1;
            end
        end
    end

    assign n_pkts  = n_pkts_r;
    assign n_drops = n_drops_r;
`else
    assign n_pkts  = 32'd0;
    assign n_drops = 16'd0;
`endif

endmodule
